// File: rtl/pipo_load_arbiter_pkg.sv
// Shared types and width helpers for the round-robin PIPO load arbiter.
// Imported by the arbiter core and by the top-level sequencer.
package pipo_load_arbiter_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } arb_state_t;

  // Source-index width; a single requester index still needs one bit.
  function automatic int srcw_f(input int nreq);
    return (nreq > 2) ? $clog2(nreq) : 1;
  endfunction

  // Hold counter must be able to represent the value HOLD itself.
  function automatic int cntw_f(input int hold);
    return (hold > 0) ? $clog2(hold + 1) : 1;
  endfunction

endpackage

// File: rtl/pipo_load_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or after ptr,
// wrapping from NREQ-1 back to 0.
module rr_arbiter
  import pipo_load_arbiter_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int SRCW = srcw_f(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [SRCW-1:0] ptr,
  output logic [NREQ-1:0] gnt,
  output logic [SRCW-1:0] gnt_idx,
  output logic            any
);

  int w_idx;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    w_idx   = 0;
    for (int k = 0; k < NREQ; k++) begin
      w_idx = int'(ptr) + k;
      if (w_idx >= NREQ) w_idx = w_idx - NREQ;
      if (!any && req[w_idx]) begin
        any          = 1'b1;
        gnt[w_idx]   = 1'b1;
        gnt_idx      = w_idx[SRCW-1:0];
      end
    end
  end

endmodule

// File: rtl/pipo_load_arbiter.sv
// Shares one parallel-load holding register among NREQ requesters; each
// loaded word stays valid for at least HOLD cycles and until out_ack.
module pipo_load_arbiter
  import pipo_load_arbiter_pkg::*;
#(
  parameter int WIDTH = 3,
  parameter int NREQ  = 4,
  parameter int HOLD  = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [NREQ*WIDTH-1:0]     req_data,
  output logic [NREQ-1:0]           req_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic                      out_valid,
  output logic [srcw_f(NREQ)-1:0]   out_src,
  input  logic                      out_ack
);

  localparam int SRCW = srcw_f(NREQ);
  localparam int CNTW = cntw_f(HOLD);
  localparam logic [CNTW-1:0] HOLD_C   = CNTW'(HOLD);
  localparam logic [CNTW-1:0] CNT_ONE  = CNTW'(1);
  localparam logic [SRCW-1:0] LAST_IDX = SRCW'(NREQ - 1);

  if (NREQ < 2) begin : g_nreq_chk
    $error("pipo_load_arbiter: NREQ must be at least 2");
  end
  if (HOLD < 1) begin : g_hold_chk
    $error("pipo_load_arbiter: HOLD must be at least 1");
  end

  arb_state_t         r_state, w_state_nxt;
  logic [SRCW-1:0]    r_ptr, w_ptr_nxt;
  logic [CNTW-1:0]    r_hold_cnt, w_cnt_nxt;
  logic               r_valid, w_valid_nxt;
  logic [WIDTH-1:0]   r_data;
  logic [SRCW-1:0]    r_src;

  logic [NREQ-1:0]    w_gnt;
  logic [SRCW-1:0]    w_gnt_idx;
  logic               w_any;
  logic               w_load;
  logic               w_hold_done;
  logic [NREQ-1:0]    w_ready;
  logic [WIDTH-1:0]   w_word;
  logic [SRCW-1:0]    w_ptr_inc;

  rr_arbiter #(
    .NREQ (NREQ),
    .SRCW (SRCW)
  ) u_rr_arbiter (
    .req     (req_valid),
    .ptr     (r_ptr),
    .gnt     (w_gnt),
    .gnt_idx (w_gnt_idx),
    .any     (w_any)
  );

  assign w_word      = req_data[w_gnt_idx*WIDTH +: WIDTH];
  assign w_ptr_inc   = (w_gnt_idx == LAST_IDX) ? '0 : w_gnt_idx + 1'b1;
  assign w_hold_done = (r_hold_cnt >= HOLD_C);

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_cnt_nxt   = r_hold_cnt;
    w_valid_nxt = r_valid;
    w_load      = 1'b0;
    w_ready     = '0;
    case (r_state)
      ST_IDLE: begin
        w_ready = w_gnt;
        if (w_any) begin
          w_load      = 1'b1;
          w_state_nxt = ST_HOLD;
          w_valid_nxt = 1'b1;
          w_cnt_nxt   = CNT_ONE;
          w_ptr_nxt   = w_ptr_inc;
        end
      end
      ST_HOLD: begin
        // Acks arriving before the minimum hold has elapsed are dropped.
        if (!w_hold_done) begin
          w_cnt_nxt = r_hold_cnt + 1'b1;
        end else if (out_ack) begin
          w_state_nxt = ST_IDLE;
          w_valid_nxt = 1'b0;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_valid_nxt = 1'b0;
      end
    endcase
  end

  // Ready is masked during reset so no producer believes it was served.
  assign req_ready = rst ? '0 : w_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_ptr      <= '0;
      r_hold_cnt <= '0;
      r_valid    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_ptr      <= w_ptr_nxt;
      r_hold_cnt <= w_cnt_nxt;
      r_valid    <= w_valid_nxt;
    end
  end

  // The held word is cleared by reset so an aborted transfer leaves no residue.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data <= '0;
      r_src  <= '0;
    end else if (w_load) begin
      r_data <= w_word;
      r_src  <= w_gnt_idx;
    end
  end

  assign out_data  = r_data;
  assign out_src   = r_src;
  assign out_valid = r_valid;

endmodule

// File: doc/pipo_load_arbiter.md
# pipo_load_arbiter

Round-robin arbiter and sequencer that shares one parallel-in/parallel-out holding register among `NREQ` requesters. Each requester offers a `WIDTH`-bit word with a valid/ready handshake. The block grants one requester at a time and loads its word into the shared register. It then holds the output stable for at least `HOLD` cycles and until the downstream consumer acknowledges. It sits between several producer blocks and a single parallel-load consumer in the register datapath.

## Interface
Parameters:
- `WIDTH`, 3: data width of each word and of the shared register.
- `NREQ`, 4: number of requesters; must be at least 2.
- `HOLD`, 2: minimum number of cycles `out_valid` stays high per load; must be at least 1.

Ports:
- `clk`, input, 1: clock. All state updates on the rising edge.
- `rst`, input, 1: reset. Synchronous, active-high.
- `req_valid`, input, NREQ: bit i is set when requester i offers a word.
- `req_data`, input, NREQ*WIDTH: word of requester i at bits [i*WIDTH +: WIDTH].
- `req_ready`, output, NREQ: one-hot or zero; combinational grant to the winning requester.
- `out_data`, output, WIDTH: contents of the shared register.
- `out_valid`, output, 1: set while the register holds a freshly loaded word.
- `out_src`, output, SRCW = max(1, clog2(NREQ)): index of the requester whose word is in `out_data`.
- `out_ack`, input, 1: consumer acknowledges the word; sampled only in HOLD.

## Operation
The controller is a two-state FSM: IDLE and HOLD.

**IDLE**
- `req_ready` is driven for the round-robin winner among the set `req_valid` bits.
- Search starts at pointer `ptr` and wraps from NREQ-1 to 0.
- If any request is pending, a transfer occurs on that edge:
  - `out_data` <= winner's word, `out_src` <= winner, `out_valid` <= 1.
  - `ptr` <= (winner+1) mod NREQ.
  - `hold_cnt` <= 1; next state is HOLD.
- If no request is pending, the state, `ptr` and registers are unchanged.

**HOLD**
- `req_ready` = 0; `out_data` and `out_src` are frozen.
- While `hold_cnt` < HOLD, `hold_cnt` increments and any `out_ack` is ignored (it is not latched).
- When `hold_cnt` >= HOLD and `out_ack` = 1: next state is IDLE and `out_valid` <= 0. `hold_cnt` saturates at HOLD.

**General rules**
- `out_data` and `out_src` keep their last value after `out_valid` falls. They are only rewritten by a new transfer.
- `req_ready` must not depend on `req_valid` of requesters other than those used by the arbitration.
- Requesters must keep `req_valid` and data stable until they see ready (AXI-style: no combinational valid-on-ready dependency).
- A requester deasserting `req_valid` before it is granted simply loses its turn; no error is raised.
- Requesters that are not selected receive no indication other than `req_ready` = 0.

## Timing
- Reset values: state IDLE, `ptr` = 0, `hold_cnt` = 0, `out_data` = 0, `out_valid` = 0, `out_src` = 0. `req_ready` = 0 during the reset cycle.
- Reset asserted mid-HOLD aborts the word. The word is lost and the next cycle is IDLE with reset values.
- Transfer in cycle T: `out_valid` is high from T+1 through at least T+HOLD. The earliest next transfer is the cycle after `out_ack` is accepted, i.e. T+HOLD+1.
- Maximum throughput is one word per HOLD+1 cycles.
- `out_ack` held high continuously gives exactly HOLD cycles of `out_valid`.
- Simultaneous events:
  - All requesters valid: grants rotate 0,1,2,3,0,...
  - `rst` together with a transfer: reset wins and no grant takes effect.

## Structure
- Shared package holds:
  - the state enum (IDLE, HOLD);
  - SRCW derivation as a function of NREQ;
  - the counter width, clog2(HOLD+1).
- One sub-module, `rr_arbiter`:
  - inputs: `req` vector, `ptr`;
  - outputs: one-hot `gnt`, binary `gnt_idx`, `any`;
  - purely combinational.
- The FSM, counter, pointer and output register live in the top module.

## Test plan
- **Reset then single request:** reset, then requester 2 valid with data 3'b101. Expect `req_ready` = 4'b0100 in that cycle. Next cycle `out_data` = 101, `out_src` = 2, `out_valid` = 1.
- **Round-robin fairness:** all four requesters valid continuously, `out_ack` = 1. Expect grants to 0,1,2,3,0 at cycles spaced by HOLD+1 = 3.
- **Pointer skip:** `ptr` = 1, only requesters 0 and 3 valid. Expect grant to 3, then to 0, not 0 twice.
- **Minimum hold and early ack:** `out_ack` = 1 in the first HOLD cycle only, then 0 for 4 cycles, then 1. Expect `out_valid` high for 6 cycles total and `out_data` unchanged throughout.
- **Reset mid-HOLD:** `rst` pulsed in the 2nd HOLD cycle. Expect `out_valid` = 0, `out_data` = 0, `ptr` = 0 the next cycle, and the pending requester regranted afterwards.
- **Idle stability:** no `req_valid` for 10 cycles after a word is released. Expect `out_data` and `out_src` held, `out_valid` = 0, `req_ready` = 0.
